cnt_tick_gen: RTL
=================

# cnt_tick_gen

Programmable tick generator that drives the single-cycle `en` input of the downstream N-bit `counter`. It accepts a divide ratio and a burst length through a valid/ready configuration port. After `start` it issues a burst of evenly spaced enable pulses, then reports completion. It sits directly upstream of the counter and sets the rate and number of counter increments.

## Interface
- `N`, 7, burst/tick-count width; matches counter width
- `DIV_W`, 8, divide-ratio width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration can be accepted (high only in IDLE)
- `cfg_div`  in  DIV_W  tick period minus one; one tick every cfg_div+1 cycles
- `cfg_burst`  in  N  ticks per burst; 0 = free-run until `stop`
- `start`  in  1  begin burst (honoured in ARMED only)
- `stop`  in  1  abort (honoured in ARMED/RUN)
- `en`  out  1  single-cycle tick to counter `en`
- `busy`  out  1  state is ARMED or RUN
- `done`  out  1  one-cycle burst-complete pulse
- `tick_cnt`  out  N  ticks issued in current burst

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE:
  - `cfg_valid && cfg_ready` latches `div_q`, `burst_q` and clears `tick_cnt` -> ARMED.
  - `start` is ignored in IDLE.
- ARMED:
  - `stop` -> IDLE.
  - Otherwise `start` -> RUN with prescaler `pre` = 0.
- RUN:
  - `pre` counts 0..`div_q`, then wraps to 0.
  - `en` = (state==RUN) && (pre==div_q). It is driven from registers only.
  - Each `en` cycle increments `tick_cnt`, modulo 2^N.
  - When `burst_q != 0` and the tick makes `tick_cnt+1 == burst_q` -> DONE.
  - `stop` -> IDLE. A tick in the same cycle is still issued and counted.
- DONE: `done`=1 for one cycle -> IDLE. `tick_cnt` is held until the next configuration is accepted.
- `cfg_valid` outside IDLE is ignored, because `cfg_ready` is low there.
- Simultaneous events:
  - `cfg_valid` and `start` in IDLE: the configuration is accepted and `start` is dropped.
  - `stop` and the final burst tick in the same cycle: `stop` wins -> IDLE, no `done`.
  - `start` and `stop` in ARMED: `stop` wins.
- Arithmetic:
  - `div_q`=0 gives `en` every RUN cycle.
  - In free-run, `tick_cnt` wraps from 2^N-1 to 0 without event.

## Timing
- Reset values: state IDLE, `cfg_ready`=1, `en`=0, `busy`=0, `done`=0, `tick_cnt`=0, `pre`=0, `div_q`=0, `burst_q`=0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Configuration accepted at edge t: `busy`=1 from t+1.
- `start` sampled at edge t: the first `en` falls in cycle t+1+div_q. Later ticks follow every div_q+1 cycles.
- `done` is high in the cycle after the final `en`. `busy` is 0 in that cycle.
- `stop` sampled at edge t: IDLE, `en`=0 and `cfg_ready`=1 from t+1.

## Configuration
- Macro: `CNT_TICK_GEN_AUTORELOAD_EN`.
- Defined:
  - DONE -> RUN instead of IDLE, with `pre` and `tick_cnt` cleared and the same `div_q`/`burst_q`.
  - `done` still pulses every burst. `busy` stays low only during the DONE cycle.
  - Only `stop` or `rst` returns to IDLE.
- Undefined: DONE -> IDLE as described above.

## Structure
- Package `cnt_tick_gen_pkg` holds:
  - the state enum `tick_state_t` (IDLE, ARMED, RUN, DONE; 2-bit);
  - default width constants `TICK_N`=7 and `TICK_DIV_W`=8.
- Sub-module `tick_prescaler`:
  - holds `pre` and the `div_q` compare;
  - inputs: `clk`, `rst`, `clr`, `run`, `div_q`;
  - output: `tick`.
- The top level holds the FSM, `tick_cnt`, the configuration registers and burst compare.

## Test plan
- `div`=3, `burst`=4, `start` at edge 0: `en` at cycles 4, 8, 12, 16; `done` at 17; `tick_cnt`=4; `busy`=0 from 17.
- `div`=0, `burst`=0, run 130 cycles: `en` every cycle; `tick_cnt` 127->0 wrap at the 128th tick; no `done`; then `stop` -> IDLE next cycle.
- `div`=2, `burst`=10, `stop` one cycle after the 2nd tick: IDLE, no `done`, `tick_cnt`=2. Repeat with `stop` on the 10th tick's cycle: `tick_cnt`=10, no `done`.
- `cfg_valid` with `div`=5 during RUN: ignored, period unchanged. `start` in IDLE: no state change. `cfg_valid` and `start` together in IDLE: ARMED only.
- `rst` low mid-RUN (div=1, burst=8): `en`, `busy`, `tick_cnt` go to 0 immediately; `cfg_ready`=1.
- With `CNT_TICK_GEN_AUTORELOAD_EN`, `div`=1, `burst`=2: `en` at RUN cycles 2 and 4, `done` at 5, repeating with period 5 until `stop`.

Source files
------------

// File: rtl/cnt_tick_gen_pkg.sv
// Shared types and default widths for the cnt_tick_gen tick generator.
package cnt_tick_gen_pkg;

  localparam int TICK_N     = 7;
  localparam int TICK_DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } tick_state_t;

endpackage

// File: rtl/cnt_tick_gen_if.sv
// Configuration / control / status bundle of cnt_tick_gen.
// The master side configures and starts bursts; the slave side (generator) reports status.
interface cnt_tick_gen_if
  import cnt_tick_gen_pkg::*;
#(
  parameter int N     = TICK_N,
  parameter int DIV_W = TICK_DIV_W
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [N-1:0]     cfg_burst;
  logic             start;
  logic             stop;
  logic             en;
  logic             busy;
  logic             done;
  logic [N-1:0]     tick_cnt;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, en, busy, done, tick_cnt
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, en, busy, done, tick_cnt
  );

endinterface

// File: rtl/cnt_tick_gen_prescaler.sv
// Tick prescaler: pre counts 0..div_q while running and flags the tick on the top value.
module tick_prescaler
  import cnt_tick_gen_pkg::*;
#(
  parameter int DIV_W = TICK_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div_q,
  output logic             tick
);

  logic [DIV_W-1:0] pre_r;
  logic             at_top_s;

  assign at_top_s = (pre_r == div_q);

  // Prescaler count: cleared outside RUN so every burst starts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      pre_r <= {DIV_W{1'b0}};
    end else if (run) begin
      pre_r <= at_top_s ? {DIV_W{1'b0}} : (pre_r + {{(DIV_W-1){1'b0}}, 1'b1});
    end else begin
      pre_r <= pre_r;
    end
  end

  assign tick = run && at_top_s;

endmodule

// File: rtl/cnt_tick_gen.sv
// cnt_tick_gen: issues bursts of evenly spaced single-cycle enables for a downstream counter.
// Build option CNT_TICK_GEN_AUTORELOAD_EN: after DONE the same burst restarts instead of idling.
module cnt_tick_gen
  import cnt_tick_gen_pkg::*;
#(
  parameter int N     = TICK_N,
  parameter int DIV_W = TICK_DIV_W
) (
  input logic           clk,
  input logic           rst,
  cnt_tick_gen_if.slave tg
);

  tick_state_t      state_r;
  logic [DIV_W-1:0] div_q_r;
  logic [N-1:0]     burst_q_r;
  logic [N-1:0]     tick_cnt_r;
  logic [N-1:0]     tick_nxt_s;
  logic             run_s;
  logic             clr_s;
  logic             tick_s;
  logic             last_tick_s;

  assign run_s = (state_r == RUN);
  assign clr_s = !run_s;

  tick_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .run   (run_s),
    .div_q (div_q_r),
    .tick  (tick_s)
  );

  // Next tick count (wraps modulo 2^N) and final-tick detection; burst 0 never ends
  always_comb begin
    tick_nxt_s  = tick_cnt_r + {{(N-1){1'b0}}, 1'b1};
    last_tick_s = 1'b0;
    if (tick_s && (burst_q_r != {N{1'b0}}) && (tick_nxt_s == burst_q_r)) begin
      last_tick_s = 1'b1;
    end else begin
      last_tick_s = 1'b0;
    end
  end

  // Control FSM with configuration registers and burst tick counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      div_q_r    <= {DIV_W{1'b0}};
      burst_q_r  <= {N{1'b0}};
      tick_cnt_r <= {N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (tg.cfg_valid) begin
            div_q_r    <= tg.cfg_div;
            burst_q_r  <= tg.cfg_burst;
            tick_cnt_r <= {N{1'b0}};
            state_r    <= ARMED;
          end
        end
        ARMED: begin
          if (tg.stop) begin
            state_r <= IDLE;
          end else if (tg.start) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          // A tick coinciding with stop is still counted; stop beats completion
          if (tick_s) begin
            tick_cnt_r <= tick_nxt_s;
          end
          if (tg.stop) begin
            state_r <= IDLE;
          end else if (last_tick_s) begin
            state_r <= DONE;
          end
        end
        DONE: begin
`ifdef CNT_TICK_GEN_AUTORELOAD_EN
          tick_cnt_r <= {N{1'b0}};
          state_r    <= RUN;
`else
          state_r    <= IDLE;
`endif
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tg.cfg_ready = (state_r == IDLE);
  assign tg.busy      = (state_r == ARMED) || (state_r == RUN);
  assign tg.done      = (state_r == DONE);
  assign tg.en        = tick_s;
  assign tg.tick_cnt  = tick_cnt_r;

endmodule
